// File: rtl/block_io_pkg.sv
// -----------------------------------------------------------------------------
// block_io_pkg
// Constants and types shared by the block fetch and block store stages.
//   BLOCK_W   : width of one block in bits
//   OUT_W     : width of one output beat (one byte)
//   NUM_BEATS : bytes per block
//   IDX_W     : width of the byte-position index
//   LAST_IDX  : index of the final byte in a block
//   state_e   : block_store sequencing states
// -----------------------------------------------------------------------------
package block_io_pkg;

    localparam int BLOCK_W   = 4096;
    localparam int OUT_W     = 8;
    localparam int NUM_BEATS = BLOCK_W / OUT_W;
    localparam int IDX_W     = $clog2(NUM_BEATS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        SEND = 2'd2
    } state_e;

endpackage : block_io_pkg

// File: rtl/block_store.sv
// -----------------------------------------------------------------------------
// block_store
// Accepts one BLOCK_W-bit block (text right-aligned, leading zero bytes as
// padding), strips the leading zero bytes and streams the remaining bytes
// MSB-first on a valid/ready byte interface. An all-zero block is consumed
// silently and reported with a one-cycle noop pulse.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data holds a block
//   in_ready  : block accepted when in_valid && in_ready (state-only)
//   in_data   : block, byte 0 in the top OUT_W bits
//   out_valid : out_data holds a byte
//   out_ready : byte consumed when out_valid && out_ready
//   out_data  : current byte (zero when out_valid is low)
//   out_last  : qualifies the final byte of a block
//   noop      : one-cycle pulse, an all-zero block was discarded
//   blk_cnt   : number of non-empty blocks fully emitted (wraps)
// -----------------------------------------------------------------------------
module block_store
    import block_io_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               noop,
    output logic [31:0]        blk_cnt
);

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [31:0]        blk_cnt_q, blk_cnt_d;
    logic               noop_q,  noop_d;

    logic [OUT_W-1:0]   cur_byte;
    logic [BLOCK_W-1:0] shifted;
    logic               at_last;

    // The byte under inspection is always the top of the shift register;
    // advancing to the next byte is a left shift by one beat.
    assign cur_byte = shift_q[BLOCK_W-1 -: OUT_W];
    assign shifted  = {shift_q[BLOCK_W-OUT_W-1:0], {OUT_W{1'b0}}};
    assign at_last  = (idx_q == LAST_IDX);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        noop_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    idx_d   = '0;
                    state_d = SKIP;
                end
            end

            SKIP: begin
                if (cur_byte == '0) begin
                    if (at_last) begin
                        // Every byte was zero: end-of-file marker.
                        state_d = IDLE;
                        noop_d  = 1'b1;
                    end else begin
                        shift_d = shifted;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    // First text byte found; it is presented without shifting.
                    state_d = SEND;
                end
            end

            SEND: begin
                if (out_ready) begin
                    shift_d = shifted;
                    idx_d   = idx_q + 1'b1;
                    if (at_last) begin
                        state_d   = IDLE;
                        blk_cnt_d = blk_cnt_q + 32'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            noop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            noop_q    <= noop_d;
        end
    end

    // NOTE: the wide data register carries no reset; it is always loaded on
    // acceptance before it is read, and out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // All outputs derive from registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? cur_byte : '0;
    assign out_last  = out_valid && at_last;
    assign noop      = noop_q;
    assign blk_cnt   = blk_cnt_q;

endmodule : block_store

// File: tb/tb_block_store.sv
// -----------------------------------------------------------------------------
// tb_block_store
// Scoreboard bench for block_store. The stimulus side builds each block as a
// byte array, derives the expected byte stream (leading zeros removed, last
// flag on byte NUM_BEATS-1) plus expected cycle numbers, and queues them; a
// separate monitor pops and compares on every output handshake / noop pulse.
// -----------------------------------------------------------------------------
module tb_block_store;
    import block_io_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         exp_cyc;   // expected cycle of first out_valid, -1 = unchecked
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic               out_last;
    logic               noop;
    logic [31:0]        blk_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: fixed pattern
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    beat_t       exp_q[$];
    int          noop_q[$];
    logic [31:0] exp_blk_cnt = '0;
    logic [7:0]  blk_bytes [NUM_BEATS];

    block_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .noop      (noop),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // out_ready driver, changes just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = pat[cyc % 6];
            endcase
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        beat_t      b;
        int         exp_noop;
        bit         head_seen;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        head_seen  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                head_seen  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, prev_data);
                    check("hold_last", out_last, prev_last);
                end
                if (noop) begin
                    check("noop_pending", noop_q.size() > 0, 1'b1);
                    if (noop_q.size() > 0) begin
                        exp_noop = noop_q.pop_front();
                        check("noop_cycle", cyc, exp_noop);
                        check("noop_in_ready", in_ready, 1'b1);
                        check("noop_no_valid", out_valid, 1'b0);
                    end
                end
                if (out_valid) begin
                    check("beat_pending", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        if (!head_seen) begin
                            head_seen = 1'b1;
                            if (exp_q[0].exp_cyc >= 0)
                                check("beat_cycle", cyc, exp_q[0].exp_cyc);
                        end
                        if (out_ready) begin
                            b = exp_q.pop_front();
                            check("beat_data", out_data, b.data);
                            check("beat_last", out_last, b.last);
                            head_seen = 1'b0;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    // Offer the block in blk_bytes, return the edge count at acceptance and
    // queue the expected response.
    task automatic send_block(output int e);
        logic [BLOCK_W-1:0] blk;
        int waited;
        int k;
        for (int i = 0; i < NUM_BEATS; i++)
            blk[BLOCK_W-1-OUT_W*i -: OUT_W] = blk_bytes[i];
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", waited < 3000, 1'b1);
        in_valid = 1'b1;
        in_data  = blk;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = cyc;
        k = NUM_BEATS;
        for (int i = 0; i < NUM_BEATS; i++) begin
            if (blk_bytes[i] != 8'h00) begin
                k = i;
                break;
            end
        end
        if (k == NUM_BEATS) begin
            noop_q.push_back(e + 512);
        end else begin
            for (int i = k; i < NUM_BEATS; i++) begin
                beat_t bt;
                bt.data    = blk_bytes[i];
                bt.last    = (i == NUM_BEATS - 1);
                bt.exp_cyc = (ready_mode == 0 || i == k) ? e + 1 + i : -1;
                exp_q.push_back(bt);
            end
            exp_blk_cnt++;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && noop_q.size() == 0 && in_ready) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", w < 5000, 1'b1);
        check("blk_cnt", blk_cnt, exp_blk_cnt);
    endtask

    task automatic clear_bytes();
        for (int i = 0; i < NUM_BEATS; i++) blk_bytes[i] = 8'h00;
    endtask

    task automatic load_abc();
        clear_bytes();
        blk_bytes[509] = 8'h61;
        blk_bytes[510] = 8'h62;
        blk_bytes[511] = 8'h63;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, 8'h00);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_noop"}, noop, 1'b0);
        check({tag, "_blk_cnt"}, blk_cnt, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, found, k;
        #23;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // "abc" right-aligned, full throughput.
        ready_mode = 0;
        load_abc();
        send_block(e0);
        wait_idle();

        // Full-width block with an embedded zero byte.
        for (int i = 0; i < NUM_BEATS; i++) blk_bytes[i] = 8'($urandom_range(1, 255));
        blk_bytes[0]   = 8'h41;
        blk_bytes[100] = 8'h00;
        send_block(e0);
        wait_idle();

        // All-zero block followed immediately by another block.
        clear_bytes();
        send_block(e0);
        load_abc();
        send_block(e1);
        check("accept_after_noop", e1, e0 + 513);
        wait_idle();

        // "abc" with a stalling consumer.
        ready_mode = 2;
        load_abc();
        send_block(e0);
        wait_idle();

        // Reset while byte 0x62 is on the output.
        ready_mode = 0;
        load_abc();
        send_block(e0);
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (out_valid && out_data == 8'h62) found = 1;
        end
        check("found_0x62", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        noop_q.delete();
        exp_blk_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_bytes();
        blk_bytes[511] = 8'h7A;
        send_block(e0);
        wait_idle();

        // Randomized blocks: random padding length, content and back-pressure.
        for (int n = 0; n < 10; n++) begin
            ready_mode = n % 2;
            clear_bytes();
            case (n % 5)
                0:       k = 0;
                1:       k = 511;
                2:       k = NUM_BEATS;   // all zero
                default: k = $urandom_range(1, 510);
            endcase
            if (k < NUM_BEATS) begin
                blk_bytes[k] = 8'($urandom_range(1, 255));
                for (int i = k + 1; i < NUM_BEATS; i++)
                    blk_bytes[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            send_block(e0);
            wait_idle();
        end

        check("leftover_beats", exp_q.size(), 0);
        check("leftover_noops", noop_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_block_store

// File: doc/block_store.md
# block_store

Writeback-side counterpart of the fetch stage. Accepts one 4096-bit block per handshake in the same format fetch produces: text right-aligned, leading zero-byte padding in the MSBs. Strips the leading zero padding and streams the remaining bytes MSB-first over a valid/ready byte interface with an end-of-block marker. All-zero blocks are end-of-file NoOps: consumed, nothing emitted, flagged by a pulse.

## Interface
- BLOCK_W, 4096, input block width in bits
- OUT_W, 8, output beat width in bits (one byte)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a block
- in_ready  output  1  block accepted when in_valid && in_ready
- in_data  input  BLOCK_W  block; byte 0 = in_data[BLOCK_W-1 -: OUT_W]
- out_valid  output  1  out_data holds a byte
- out_ready  input  1  byte consumed when out_valid && out_ready
- out_data  output  OUT_W  current byte
- out_last  output  1  with out_valid: final byte of block
- noop  output  1  one-cycle pulse: all-zero block discarded
- blk_cnt  output  32  count of non-NoOp blocks fully emitted, wraps at 2^32

## Operation
- Reset: single clock; reset is asynchronous and active-low. State IDLE, in_ready=1, out_valid=0, out_data=0, out_last=0, noop=0, blk_cnt=0, index=0.
- Block held in a BLOCK_W shift register; current byte is always the top OUT_W bits; a shift moves the register left by OUT_W. 9-bit index (NUM_BEATS = BLOCK_W/OUT_W = 512) tracks byte position.
- IDLE: in_ready=1. On accept: load shift register, index=0, go SKIP.
- SKIP: in_ready=0, out_valid=0. Current byte zero and index<511: shift, index+1, stay. Current byte zero and index==511: go IDLE, assert noop next cycle, blk_cnt unchanged. Current byte nonzero: go SEND, no shift.
- SEND: out_valid=1, out_data=current byte, out_last=(index==511). On handshake: shift, index+1; if out_last, go IDLE and blk_cnt+1.
- Only leading zeros are stripped; zero bytes after the first nonzero byte are emitted.
- out_data/out_last held stable while out_valid && !out_ready.
- Reset mid-block: asynchronous clear to reset values; partial block discarded, no out_last, blk_cnt cleared.

## Timing
- in_ready depends on state only; no combinational path from out_ready or in_valid to any output.
- Accept in cycle T; with k leading zero bytes (0<=k<=511), first out_valid in cycle T+2+k.
- With out_ready held high, one byte per cycle; last byte in cycle T+1+512 = T+513 regardless of k; IDLE and in_ready=1 in cycle T+514.
- All-zero block: byte 511 examined in T+512; noop=1 and in_ready=1 in T+513 only.
- No back-to-back acceptance: at least one IDLE cycle between blocks.

## Structure
- Shared package block_io_pkg: BLOCK_W, OUT_W, NUM_BEATS, index width, state enum (IDLE, SKIP, SEND). Fetch adopts the same BLOCK_W constant.
- No sub-module: one state machine, one shift register, one index counter, one block counter.

## Test plan
- Reset asserted mid-run: in_ready=1, out_valid=0, out_last=0, noop=0, blk_cnt=0 immediately, no clk edge needed.
- Block with bytes 509..511 = 0x61,0x62,0x63, rest 0, out_ready=1, accept at T: out_valid first at T+511; 0x61,0x62,0x63 in T+511..T+513; out_last only with 0x63; blk_cnt=1.
- Full block byte 0 = 0x41, byte 100 = 0x00: 512 beats T+2..T+513 including the 0x00; out_last on beat 511.
- All-zero block: out_valid never asserted; noop=1 for exactly cycle T+513; blk_cnt unchanged; next block accepted in T+513.
- "abc" block with out_ready toggling 1,0,0,1,0,1: each byte held while stalled; exactly 0x61,0x62,0x63 delivered, no drops or duplicates.
- rst_n pulsed low during SEND of byte 0x62: out_valid drops at once; subsequent block 0x7A in byte 511 emits single beat 0x7A with out_last, blk_cnt=1.
